// File: rtl/valid_array_flush_sequencer_pkg.sv
// Shared cache geometry defaults. The valid array, the tag array and the
// flush sequencer all take their sizing defaults from here.
package valid_array_flush_sequencer_pkg;

   localparam int unsigned CACHE_NUMBER_SETS = 64;
   localparam int unsigned CACHE_NUMBER_WAYS = 16;

endpackage : valid_array_flush_sequencer_pkg

// File: rtl/valid_array_flush_sequencer.sv
// Flush sequencer that owns the access port of the per-way cache valid array.
// While idle, it passes controller lookups and fills straight through with no
// added latency. On request, or optionally when leaving reset, it stalls the
// controller and writes valid=0 to every way of one set per cycle. When the
// last set has been written, it pulses flush_done_out for one cycle.
module valid_array_flush_sequencer
   import valid_array_flush_sequencer_pkg::*;
#(
   parameter int unsigned NUMBER_SETS           = CACHE_NUMBER_SETS,
   parameter int unsigned NUMBER_WAYS           = CACHE_NUMBER_WAYS,
   parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS),
   parameter bit          FLUSH_ON_RESET        = 1'b1
) (
   input  logic                             clk_in,
   input  logic                             reset_in,
   input  logic                             flush_req_in,
   output logic                             flush_busy_out,
   output logic                             flush_done_out,
   input  logic                             client_access_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0] client_set_addr_in,
   input  logic                             client_write_en_in,
   input  logic [NUMBER_WAYS-1:0]           client_way_select_in,
   input  logic                             client_write_valid_in,
   output logic                             client_stall_out,
   output logic                             access_en_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0] set_addr_out,
   output logic                             write_en_out,
   output logic [NUMBER_WAYS-1:0]           way_select_out,
   output logic                             write_valid_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam state_e RESET_EXIT_STATE = FLUSH_ON_RESET ? ST_FLUSH : ST_IDLE;
   localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
      SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

   state_e                           state_q;
   logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_set_q;

   // Sequencer FSM and set walker: IDLE -> FLUSH (one set per cycle) -> DONE -> IDLE.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q     <= RESET_EXIT_STATE;
         flush_set_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (flush_req_in) begin
                  state_q     <= ST_FLUSH;
                  flush_set_q <= '0;
               end
            end
            ST_FLUSH: begin
               // The counter wraps to zero naturally after the last set because
               // NUMBER_SETS is a power of two.
               flush_set_q <= flush_set_q + 1'b1;
               if (flush_set_q == LAST_SET) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Array port multiplexing and status: client pass-through while idle,
   // invalidate writes while flushing, and everything quiet in reset and DONE.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      access_en_out    = 1'b0;
      set_addr_out     = '0;
      write_en_out     = 1'b0;
      way_select_out   = '0;
      write_valid_out  = 1'b0;
      client_stall_out = 1'b1;
      flush_busy_out   = 1'b1;
      flush_done_out   = 1'b0;

      // While reset is held, the array port stays quiet and the controller is
      // stalled no matter which state the register still holds.
      if (!reset_in) begin
         unique case (state_q)
            ST_IDLE: begin
               access_en_out    = client_access_en_in;
               set_addr_out     = client_set_addr_in;
               write_en_out     = client_write_en_in;
               way_select_out   = client_way_select_in;
               write_valid_out  = client_write_valid_in;
               client_stall_out = 1'b0;
               flush_busy_out   = 1'b0;
            end
            ST_FLUSH: begin
               access_en_out   = 1'b1;
               set_addr_out    = flush_set_q;
               write_en_out    = 1'b1;
               way_select_out  = '1;
               write_valid_out = 1'b0;
            end
            ST_DONE: begin
               flush_done_out = 1'b1;
            end
            default: begin
               flush_done_out = 1'b0;
            end
         endcase
      end
   end

endmodule : valid_array_flush_sequencer

// File: tb/tb_valid_array_flush_sequencer.sv
// Self-checking bench for valid_array_flush_sequencer. It uses two instances:
// a 64-set instance that flushes on reset and a 2-set instance that leaves
// reset in IDLE. The initial block drives stimulus on the falling edge and
// pushes the expected port values to a scoreboard queue at the same time.
// Shortly afterwards it pops those values and compares them with the outputs.
module tb_valid_array_flush_sequencer;

   // Observed and expected port bundle:
   // {access_en, set[5:0], write_en, way[15:0], write_valid, stall, busy, done}
   localparam logic [27:0] MASK_FULL = 28'hFFF_FFFF;
   // Excludes set and way, which carry no defined value when the array is disabled.
   localparam logic [27:0] MASK_CTRL = 28'h810_000F;

   typedef struct {
      logic [27:0] value;
      logic [27:0] mask;
      string       tag;
   } exp_t;

   exp_t big_q[$];
   exp_t small_q[$];

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 64-set, flush-on-reset instance
   logic        rst, req, c_acc, c_we, c_val;
   logic [5:0]  c_set;
   logic [15:0] c_way;
   logic        busy, done, stall, acc, we, val;
   logic [5:0]  set;
   logic [15:0] way;

   // 2-set, idle-on-reset instance
   logic        s_rst, s_req, s_c_acc, s_c_we, s_c_val;
   logic [0:0]  s_c_set;
   logic [15:0] s_c_way;
   logic        s_busy, s_done, s_stall, s_acc, s_we, s_val;
   logic [0:0]  s_set;
   logic [15:0] s_way;

   valid_array_flush_sequencer #(
      .NUMBER_SETS(64), .NUMBER_WAYS(16), .SET_PTR_WIDTH_IN_BITS(6), .FLUSH_ON_RESET(1'b1)
   ) dut (
      .clk_in(clk), .reset_in(rst), .flush_req_in(req),
      .flush_busy_out(busy), .flush_done_out(done),
      .client_access_en_in(c_acc), .client_set_addr_in(c_set),
      .client_write_en_in(c_we), .client_way_select_in(c_way),
      .client_write_valid_in(c_val), .client_stall_out(stall),
      .access_en_out(acc), .set_addr_out(set), .write_en_out(we),
      .way_select_out(way), .write_valid_out(val)
   );

   valid_array_flush_sequencer #(
      .NUMBER_SETS(2), .NUMBER_WAYS(16), .SET_PTR_WIDTH_IN_BITS(1), .FLUSH_ON_RESET(1'b0)
   ) dut_small (
      .clk_in(clk), .reset_in(s_rst), .flush_req_in(s_req),
      .flush_busy_out(s_busy), .flush_done_out(s_done),
      .client_access_en_in(s_c_acc), .client_set_addr_in(s_c_set),
      .client_write_en_in(s_c_we), .client_way_select_in(s_c_way),
      .client_write_valid_in(s_c_val), .client_stall_out(s_stall),
      .access_en_out(s_acc), .set_addr_out(s_set), .write_en_out(s_we),
      .way_select_out(s_way), .write_valid_out(s_val)
   );

   function automatic logic [27:0] pack(input logic a, input logic [5:0] s, input logic w,
                                        input logic [15:0] ws, input logic v, input logic st,
                                        input logic b, input logic d);
      return {a, s, w, ws, v, st, b, d};
   endfunction

   task automatic drive_big(input logic r, input logic q, input logic a, input logic [5:0] s,
                            input logic w, input logic [15:0] ws, input logic v);
      rst = r; req = q; c_acc = a; c_set = s; c_we = w; c_way = ws; c_val = v;
   endtask

   task automatic drive_small(input logic r, input logic q, input logic a, input logic s,
                              input logic w, input logic [15:0] ws, input logic v);
      s_rst = r; s_req = q; s_c_acc = a; s_c_set = s; s_c_we = w; s_c_way = ws; s_c_val = v;
   endtask

   task automatic exp_big(input string tag, input logic [27:0] v, input logic [27:0] m);
      exp_t e;
      e.value = v; e.mask = m; e.tag = tag;
      big_q.push_back(e);
   endtask

   task automatic exp_small(input string tag, input logic [27:0] v, input logic [27:0] m);
      exp_t e;
      e.value = v; e.mask = m; e.tag = tag;
      small_q.push_back(e);
   endtask

   // Compare pending expectations against the settled outputs, then advance one cycle.
   task automatic tick();
      exp_t        e;
      logic [27:0] obs;
      #1;
      if (big_q.size() > 0) begin
         e   = big_q.pop_front();
         obs = pack(acc, set, we, way, val, stall, busy, done);
         checks++;
         assert ((obs & e.mask) === (e.value & e.mask)) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.value & e.mask);
         end
      end
      if (small_q.size() > 0) begin
         e   = small_q.pop_front();
         obs = pack(s_acc, {5'b0, s_set}, s_we, s_way, s_val, s_stall, s_busy, s_done);
         checks++;
         assert ((obs & e.mask) === (e.value & e.mask)) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.value & e.mask);
         end
      end
      @(negedge clk);
   endtask

   // Flush cycles on the big instance, with client noise that must be ignored.
   task automatic walk_big(input int n, input logic q, input string pfx);
      for (int i = 0; i < n; i++) begin
         drive_big(1'b0, q, 1'b1, 6'd7, 1'b1, 16'h0001, 1'b1);
         exp_big($sformatf("%s_set%0d", pfx, i),
                 pack(1'b1, 6'(i), 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0), MASK_FULL);
         tick();
      end
   endtask

   task automatic done_big(input logic q, input string pfx);
      drive_big(1'b0, q, 1'b1, 6'd2, 1'b1, 16'h0002, 1'b1);
      exp_big({pfx, "_done"}, pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1), MASK_CTRL);
      tick();
   endtask

   task automatic idle_quiet_big(input logic q, input string tag);
      drive_big(1'b0, q, 1'b0, 6'd0, 1'b0, 16'h0, 1'b0);
      exp_big(tag, pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();
   endtask

   initial begin
      drive_big(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0, 1'b0);
      drive_small(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);

      // Reset cycles: the array port is quiet and the controller is stalled,
      // even with client activity present.
      for (int i = 0; i < 2; i++) begin
         drive_big(1'b1, 1'b1, 1'b1, 6'd12, 1'b1, 16'h00F0, 1'b1);
         exp_big("reset", pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0), MASK_CTRL);
         tick();
      end

      // Flush on reset: sets 0..63 in cycles 1..64, done pulse in cycle 65.
      walk_big(64, 1'b0, "por");
      done_big(1'b0, "por");

      // Idle pass-through with several client patterns.
      drive_big(1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 16'h0004, 1'b1);
      exp_big("pass_fill", pack(1'b1, 6'd5, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();
      drive_big(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 16'hFFFF, 1'b0);
      exp_big("pass_lookup", pack(1'b1, 6'd63, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();
      idle_quiet_big(1'b0, "pass_quiet");

      // A request with a concurrent client write forwards that write, then flushes.
      drive_big(1'b0, 1'b1, 1'b1, 6'd9, 1'b1, 16'h0100, 1'b1);
      exp_big("req_fwd", pack(1'b1, 6'd9, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();
      walk_big(64, 1'b0, "req");
      done_big(1'b0, "req");
      idle_quiet_big(1'b0, "req_after");

      // A request held high gives exactly one walk, then restarts from IDLE.
      idle_quiet_big(1'b1, "hold_start");
      walk_big(64, 1'b1, "hold");
      done_big(1'b1, "hold");
      idle_quiet_big(1'b1, "hold_idle");

      // The second walk is aborted by reset at set 30 and restarts at set 0.
      walk_big(30, 1'b1, "abort");
      drive_big(1'b1, 1'b0, 1'b1, 6'd12, 1'b1, 16'h00F0, 1'b1);
      exp_big("abort_reset", pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0), MASK_CTRL);
      tick();
      walk_big(64, 1'b0, "restart");
      done_big(1'b0, "restart");
      idle_quiet_big(1'b0, "restart_after");

      // 2-set instance without flush on reset.
      drive_big(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0, 1'b0);
      drive_small(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1);
      exp_small("s_reset", pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0), MASK_CTRL);
      tick();
      drive_small(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b0);
      exp_small("s_idle_pass", pack(1'b1, 6'd1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();
      drive_small(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      exp_small("s_req", pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();
      drive_small(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b1);
      exp_small("s_set0", pack(1'b1, 6'd0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0), MASK_FULL);
      tick();
      exp_small("s_set1", pack(1'b1, 6'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0), MASK_FULL);
      tick();
      exp_small("s_done", pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1), MASK_CTRL);
      tick();
      drive_small(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      exp_small("s_after", pack(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), MASK_FULL);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_valid_array_flush_sequencer
